// File: rtl/hash_msg_streamer.sv
// Captures a fresh LFSR nonce, builds {prev_hash, nonce}, SHA-256-pads it to two
// 512-bit blocks and streams the 32 resulting words over a valid/ready interface.
module hash_msg_streamer #(
    parameter int HDR_W    = 256,
    parameter int NONCE_W  = 256,
    parameter int WORD_W   = 32,
    parameter int LEN_BITS = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [HDR_W-1:0]   prev_hash,
    output logic               seq_restart,
    output logic               seq_enable,
    input  logic               seq_done,
    input  logic [NONCE_W-1:0] seq_data,
    output logic [WORD_W-1:0]  w_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic               w_first,
    output logic               w_last,
    output logic               w_final,
    output logic [NONCE_W-1:0] nonce_out,
    output logic               busy,
    output logic               done
);

    localparam int          MSG_W    = HDR_W + NONCE_W;
    localparam logic [3:0]  LAST_IDX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTART = 3'd1,
        ST_GATHER  = 3'd2,
        ST_BLK0    = 3'd3,
        ST_BLK1    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t               state_r;
    logic [3:0]           index_r;
    logic [HDR_W-1:0]     hdr_r;
    logic [MSG_W-1:0]     msg_r;
    logic [NONCE_W-1:0]   nonce_r;
    logic [WORD_W-1:0]    w_data_r;
    logic                 w_valid_r;
    logic                 w_first_r;
    logic                 w_last_r;
    logic                 w_final_r;
    logic                 seq_restart_r;
    logic                 seq_enable_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 xfer_s;
    logic [3:0]           index_inc_s;

    // Word idx of the message block, most significant word first.
    function automatic logic [WORD_W-1:0] msg_word(input logic [MSG_W-1:0] msg,
                                                   input logic [3:0] idx);
        msg_word = msg[MSG_W - WORD_W - WORD_W * int'(idx) +: WORD_W];
    endfunction

    // Padding block: leading 1 bit, zero fill, 64-bit length with upper half in word 14.
    function automatic logic [WORD_W-1:0] pad_word(input logic [3:0] idx);
        case (idx)
            4'd0:    pad_word = 32'h8000_0000;
            4'd15:   pad_word = WORD_W'(LEN_BITS);
            default: pad_word = {WORD_W{1'b0}};
        endcase
    endfunction

    assign xfer_s      = w_valid_r & w_ready;
    assign index_inc_s = index_r + 4'd1;

    // Job sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            index_r       <= 4'd0;
            hdr_r         <= {HDR_W{1'b0}};
            msg_r         <= {MSG_W{1'b0}};
            nonce_r       <= {NONCE_W{1'b0}};
            w_data_r      <= {WORD_W{1'b0}};
            w_valid_r     <= 1'b0;
            w_first_r     <= 1'b0;
            w_last_r      <= 1'b0;
            w_final_r     <= 1'b0;
            seq_restart_r <= 1'b0;
            seq_enable_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        hdr_r         <= prev_hash;
                        seq_restart_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ST_RESTART;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RESTART: begin
                    seq_restart_r <= 1'b0;
                    seq_enable_r  <= 1'b1;
                    state_r       <= ST_GATHER;
                end
                ST_GATHER: begin
                    if (seq_done) begin
                        msg_r        <= {hdr_r, seq_data};
                        nonce_r      <= seq_data;
                        index_r      <= 4'd0;
                        seq_enable_r <= 1'b0;
                        w_data_r     <= hdr_r[HDR_W-1 -: WORD_W];
                        w_valid_r    <= 1'b1;
                        w_first_r    <= 1'b1;
                        w_last_r     <= 1'b0;
                        w_final_r    <= 1'b0;
                        state_r      <= ST_BLK0;
                    end else begin
                        state_r <= ST_GATHER;
                    end
                end
                ST_BLK0: begin
                    if (xfer_s && (index_r == LAST_IDX)) begin
                        index_r   <= 4'd0;
                        w_data_r  <= pad_word(4'd0);
                        w_first_r <= 1'b1;
                        w_last_r  <= 1'b0;
                        w_final_r <= 1'b1;
                        state_r   <= ST_BLK1;
                    end else if (xfer_s) begin
                        index_r   <= index_inc_s;
                        w_data_r  <= msg_word(msg_r, index_inc_s);
                        w_first_r <= 1'b0;
                        w_last_r  <= (index_inc_s == LAST_IDX);
                    end else begin
                        state_r <= ST_BLK0;
                    end
                end
                ST_BLK1: begin
                    if (xfer_s && (index_r == LAST_IDX)) begin
                        index_r   <= 4'd0;
                        w_data_r  <= {WORD_W{1'b0}};
                        w_valid_r <= 1'b0;
                        w_first_r <= 1'b0;
                        w_last_r  <= 1'b0;
                        w_final_r <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (xfer_s) begin
                        index_r   <= index_inc_s;
                        w_data_r  <= pad_word(index_inc_s);
                        w_first_r <= 1'b0;
                        w_last_r  <= (index_inc_s == LAST_IDX);
                    end else begin
                        state_r <= ST_BLK1;
                    end
                end
                ST_DONE: begin
                    // A start arriving here is dropped: no job queueing.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    index_r       <= 4'd0;
                    w_data_r      <= {WORD_W{1'b0}};
                    w_valid_r     <= 1'b0;
                    w_first_r     <= 1'b0;
                    w_last_r      <= 1'b0;
                    w_final_r     <= 1'b0;
                    seq_restart_r <= 1'b0;
                    seq_enable_r  <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign seq_restart = seq_restart_r;
    assign seq_enable  = seq_enable_r;
    assign w_data      = w_data_r;
    assign w_valid     = w_valid_r;
    assign w_first     = w_first_r;
    assign w_last      = w_last_r;
    assign w_final     = w_final_r;
    assign nonce_out   = nonce_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_hash_msg_streamer.sv
// Directed bench for hash_msg_streamer with a behavioural 127-cycle LFSR generator model.
module tb_hash_msg_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] prev_hash;
    logic         seq_restart;
    logic         seq_enable;
    logic         seq_done = 1'b0;
    logic [255:0] seq_data = 256'h0;
    logic [31:0]  w_data;
    logic         w_valid;
    logic         w_ready;
    logic         w_first;
    logic         w_last;
    logic         w_final;
    logic [255:0] nonce_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int passed = 0;

    localparam logic [255:0] H_A  = {2{128'h00112233445566778899AABBCCDDEEFF}};
    localparam logic [255:0] N_A5 = {32{8'hA5}};
    localparam logic [255:0] H_B  = {8{32'h0F1E2D3C}};
    localparam logic [255:0] N_B  = {8{32'h13579BDF}};
    localparam logic [255:0] N_5A = {32{8'h5A}};

    hash_msg_streamer dut (
        .clk(clk), .reset(reset), .start(start), .prev_hash(prev_hash),
        .seq_restart(seq_restart), .seq_enable(seq_enable), .seq_done(seq_done),
        .seq_data(seq_data), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_first(w_first), .w_last(w_last), .w_final(w_final), .nonce_out(nonce_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // LFSR generator model: done after 127 enabled cycles, cleared by restart or reset.
    logic [255:0] gen_value = 256'h0;
    int           gen_cnt   = 0;
    always @(negedge clk) begin
        if (reset) begin
            gen_cnt  = 0;
            seq_done = 1'b0;
        end else if (seq_restart) begin
            gen_cnt  = 0;
            seq_done = 1'b0;
        end else if (seq_enable && !seq_done) begin
            gen_cnt++;
            if (gen_cnt == 127) begin
                seq_done = 1'b1;
                seq_data = gen_value;
            end
        end
    end

    logic [31:0]  got_data  [32];
    logic [2:0]   got_flags [32];
    int           got_n;
    int           en_cycles;
    int           stall_bad;
    int           stall_cnt;
    bit           timeout;
    bit           aborted;
    logic         restart_pulse, restart_after, en_at_restart;
    logic         done_at1, valid_at1, done_at2, busy_at2;
    logic [255:0] nonce_at_gather;

    function automatic logic [31:0] exp_word(input int i, input logic [255:0] h,
                                             input logic [255:0] n);
        logic [511:0] m;
        m = {h, n};
        if (i < 16)       return m[(15 - i) * 32 +: 32];
        else if (i == 16) return 32'h8000_0000;
        else if (i == 31) return 32'h0000_0200;
        else              return 32'h0000_0000;
    endfunction

    function automatic logic [2:0] exp_flags(input int i);
        return {((i % 16) == 0), ((i % 16) == 15), (i >= 16)};
    endfunction

    task automatic launch(input logic [255:0] h, input logic [255:0] n);
        @(negedge clk);
        prev_hash = h;
        gen_value = n;
        start     = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        prev_hash     = 256'h0;
        restart_pulse = seq_restart;
        en_at_restart = seq_enable;
    endtask

    // rdy_mode 0: always ready, 1: random. poke_at: pulse start while that word transfers.
    task automatic stream(input int rdy_mode, input int poke_at, input int abort_at);
        logic        pv, pr;
        logic [34:0] pvec;
        bit          seen_en;
        got_n = 0; en_cycles = 0; stall_bad = 0; stall_cnt = 0;
        timeout = 1'b0; aborted = 1'b0; seen_en = 1'b0;
        pv = 1'b0; pr = 1'b0; pvec = 35'h0;
        for (int cyc = 0; cyc < 3000 && got_n < 32; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) restart_after = seq_restart;
            if (pv && !pr) begin
                stall_cnt++;
                if (!w_valid || ({w_data, w_first, w_last, w_final} != pvec)) stall_bad++;
            end
            if (!w_valid && got_n == 0 && seq_enable) begin
                if (!seen_en) nonce_at_gather = nonce_out;
                seen_en = 1'b1;
                en_cycles++;
            end
            if (abort_at >= 0 && got_n == abort_at && w_valid) begin
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            w_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (w_valid && w_ready) begin
                got_data[got_n]  = w_data;
                got_flags[got_n] = {w_first, w_last, w_final};
                if (got_n == poke_at) start = 1'b1;
                got_n++;
            end
            pv = w_valid; pr = w_ready; pvec = {w_data, w_first, w_last, w_final};
        end
        if (!aborted) begin
            if (got_n < 32) timeout = 1'b1;
            @(negedge clk);
            start = 1'b0;
            done_at1 = done; valid_at1 = w_valid;
            @(negedge clk);
            done_at2 = done; busy_at2 = busy;
        end
    endtask

    task automatic test_reset;
        logic busy_any;
        reset = 1'b1; start = 1'b0; w_ready = 1'b0; prev_hash = 256'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({w_data, w_valid, w_first, w_last, w_final, seq_restart, seq_enable, busy, done,
             nonce_out} !== 296'h0) begin
            $display("FAIL reset_outputs: got w_data=%h w_valid=%b busy=%b nonce=%h, expected all 0",
                     w_data, w_valid, busy, nonce_out);
        end else passed++;
        reset = 1'b0;
        busy_any = 1'b0;
        repeat (10) begin
            @(negedge clk);
            busy_any |= busy | w_valid | seq_restart | seq_enable;
        end
        checks++;
        if (busy_any !== 1'b0) $display("FAIL idle_quiet: activity=%b, expected 0", busy_any);
        else passed++;
    endtask

    task automatic test_basic;
        launch(H_A, N_A5);
        stream(0, -1, -1);
        checks++;
        if ({restart_pulse, en_at_restart, restart_after} !== 3'b100)
            $display("FAIL restart_pulse: {pulse,en,after}=%b, expected 100",
                     {restart_pulse, en_at_restart, restart_after});
        else passed++;
        checks++;
        if (timeout !== 1'b0 || en_cycles != 127)
            $display("FAIL gather_latency: timeout=%b enable_cycles=%0d, expected 0/127", timeout, en_cycles);
        else passed++;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({got_data[i], got_flags[i]} !== {exp_word(i, H_A, N_A5), exp_flags(i)})
                $display("FAIL basic_word%0d: got %h flags %b, expected %h flags %b", i,
                         got_data[i], got_flags[i], exp_word(i, H_A, N_A5), exp_flags(i));
            else passed++;
        end
        checks++;
        if ({done_at1, valid_at1, done_at2, busy_at2} !== 4'b1000)
            $display("FAIL basic_done: {done,valid,done+1,busy+1}=%b, expected 1000",
                     {done_at1, valid_at1, done_at2, busy_at2});
        else passed++;
        checks++;
        if (nonce_out !== N_A5) $display("FAIL basic_nonce: got %h, expected %h", nonce_out, N_A5);
        else passed++;
    endtask

    task automatic test_backpressure;
        launch(H_A, N_A5);
        stream(1, -1, -1);
        checks++;
        if (timeout !== 1'b0 || got_n != 32)
            $display("FAIL bp_count: timeout=%b words=%0d, expected 0/32", timeout, got_n);
        else passed++;
        checks++;
        if (stall_bad != 0) $display("FAIL bp_stable: unstable stall cycles=%0d of %0d, expected 0",
                                     stall_bad, stall_cnt);
        else passed++;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({got_data[i], got_flags[i]} !== {exp_word(i, H_A, N_A5), exp_flags(i)})
                $display("FAIL bp_word%0d: got %h flags %b, expected %h flags %b", i,
                         got_data[i], got_flags[i], exp_word(i, H_A, N_A5), exp_flags(i));
            else passed++;
        end
        checks++;
        if (done_at1 !== 1'b1) $display("FAIL bp_done: got %b, expected 1", done_at1);
        else passed++;
    endtask

    task automatic test_start_midstream;
        logic busy_any;
        launch(H_A, N_A5);
        stream(0, 7, -1);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({got_data[i], got_flags[i]} !== {exp_word(i, H_A, N_A5), exp_flags(i)})
                $display("FAIL poke_word%0d: got %h flags %b, expected %h flags %b", i,
                         got_data[i], got_flags[i], exp_word(i, H_A, N_A5), exp_flags(i));
            else passed++;
        end
        checks++;
        if ({timeout, done_at1} !== 2'b01)
            $display("FAIL poke_done: {timeout,done}=%b, expected 01", {timeout, done_at1});
        else passed++;
        busy_any = busy_at2;
        repeat (5) begin
            @(negedge clk);
            busy_any |= busy | seq_restart;
        end
        checks++;
        if (busy_any !== 1'b0) $display("FAIL poke_ignored: busy seen=%b, expected 0", busy_any);
        else passed++;
        checks++;
        if (nonce_out !== N_A5) $display("FAIL poke_nonce: got %h, expected %h", nonce_out, N_A5);
        else passed++;
    endtask

    task automatic test_reset_midstream;
        launch(H_A, N_A5);
        stream(0, -1, 20);
        checks++;
        if (nonce_at_gather !== N_A5)
            $display("FAIL nonce_hold: got %h, expected %h", nonce_at_gather, N_A5);
        else passed++;
        #1;
        checks++;
        if (aborted !== 1'b1 ||
            {w_data, w_valid, w_first, w_last, w_final, seq_restart, seq_enable, busy, done,
             nonce_out} !== 296'h0)
            $display("FAIL abort_outputs: aborted=%b w_data=%h w_valid=%b busy=%b nonce=%h, expected all 0",
                     aborted, w_data, w_valid, busy, nonce_out);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        launch(H_B, N_B);
        stream(0, -1, -1);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({got_data[i], got_flags[i]} !== {exp_word(i, H_B, N_B), exp_flags(i)})
                $display("FAIL rerun_word%0d: got %h flags %b, expected %h flags %b", i,
                         got_data[i], got_flags[i], exp_word(i, H_B, N_B), exp_flags(i));
            else passed++;
        end
        checks++;
        if ({timeout, done_at1} !== 2'b01)
            $display("FAIL rerun_done: {timeout,done}=%b, expected 01", {timeout, done_at1});
        else passed++;
    endtask

    task automatic test_stale_done;
        logic pre_done;
        @(negedge clk);
        pre_done = seq_done;
        launch(H_A, N_5A);
        stream(0, -1, -1);
        checks++;
        if ({pre_done, restart_pulse, restart_after} !== 3'b110)
            $display("FAIL stale_restart: {pre_done,pulse,after}=%b, expected 110",
                     {pre_done, restart_pulse, restart_after});
        else passed++;
        checks++;
        if (en_cycles != 127 || nonce_at_gather !== N_B)
            $display("FAIL stale_wait: enable_cycles=%0d nonce=%h, expected 127/%h",
                     en_cycles, nonce_at_gather, N_B);
        else passed++;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({got_data[i], got_flags[i]} !== {exp_word(i, H_A, N_5A), exp_flags(i)})
                $display("FAIL stale_word%0d: got %h flags %b, expected %h flags %b", i,
                         got_data[i], got_flags[i], exp_word(i, H_A, N_5A), exp_flags(i));
            else passed++;
        end
        checks++;
        if (nonce_out !== N_5A) $display("FAIL stale_nonce: got %h, expected %h", nonce_out, N_5A);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_midstream();
        test_reset_midstream();
        test_stale_done();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
